dispatcher: RTL and testbench
=============================

// Module: dispatcher
// PURPOSE
//  Issue stage between instruction queue and back end. Takes one predecoded instruction per cycle,
//  resolves rs1/rs2 from regfile, ROB and same-cycle result broadcasts, allocates the ROB tail entry,
//  renames rd, and issues into the reservation station or the LSB. Drives the Rs issue_* bus.
// PARAMETERS
//  XLEN   32  data/pc width
//  TAG_W  4   ROB tag width; 2**TAG_W ROB entries
//  OPC_W  6   internal opcode width
// PORTS
//  clk  in 1  clock, all state on posedge
//  rst  in 1  asynchronous reset, active-low (0 = reset)
//  rdy  in 1  global enable; 0 freezes all state and suppresses all strobes
//  clear  in 1  misprediction flush
//  iq_valid/iq_ready  in/out 1  instruction-queue handshake
//  iq_opcode/iq_is_ls  in OPC_W/1  opcode; 1 = load/store, routed to LSB
//  iq_rd/iq_rs1/iq_rs2  in 5 each  register indices (rd=0 for no destination)
//  iq_imm/iq_pc  in XLEN each  immediate, instruction pc
//  rf_rs1/rf_rs2  out 5 each  regfile lookup indices, from hold register
//  rf_busy1/rf_busy2  in 1 each  register renamed
//  rf_tag1/rf_tag2  in TAG_W each  producing ROB tag
//  rf_val1/rf_val2  in XLEN each  architectural value
//  rob_rdy1/rob_rdy2  in 1 each  ROB entry at rf_tagN has result
//  rob_val1/rob_val2  in XLEN each  that result
//  rob_full/rob_tail  in 1/TAG_W  ROB full; tag allocated on issue
//  rob_issue  out 1  ROB allocate strobe; rob_opcode/rob_rd/rob_pc out OPC_W/5/XLEN
//  rename_en/rename_rd/rename_tag  out 1/5/TAG_W  regfile rename write
//  rs_full/lsb_full  in 1 each  target cannot accept this cycle
//  is_issue/is_lsb_issue  out 1 each  issue strobe to Rs / LSB
//  issue_opcode issue_rob_id issue_imm issue_pc  out OPC_W/TAG_W/XLEN/XLEN  shared issue bus
//  issue_Vi/issue_Qi/issue_Ri  out XLEN/TAG_W/1  operand 1 value, tag, ready; _Vj/_Qj/_Rj operand 2
//  is_alu_ok/rob_id_from_alu/res_from_alu  in 1/TAG_W/XLEN  ALU broadcast
//  is_lsb_ok/rob_id_from_lsb/res_from_lsb  in 1/TAG_W/XLEN  LSB broadcast
//  is_rob_commit/rob_id_from_rob/res_from_rob  in 1/TAG_W/XLEN  ROB commit broadcast
// BEHAVIOUR
//  - State: one hold register h_valid + fields. States EMPTY (h_valid=0) / HELD (h_valid=1).
//  - fire = h_valid & rdy & !clear & !rob_full & (h_is_ls ? !lsb_full : !rs_full).
//  - iq_ready = rdy & !clear & (!h_valid | fire); accept at posedge when iq_valid & iq_ready.
//    EMPTY->HELD on accept; HELD->EMPTY on fire w/o accept; HELD->HELD on fire+accept or stall.
//  - All strobes/bus outputs combinational from hold reg, valid only while fire; strobes 0 otherwise.
//    Consumers latch on the same edge. Latency: accepted at edge N, issued earliest in cycle N+1.
//    Throughput 1 instr/cycle.
//  - On fire: is_issue=!h_is_ls, is_lsb_issue=h_is_ls, rob_issue=1, issue_rob_id=rob_tail,
//    rename_en=(h_rd!=0), rename_tag=rob_tail. rd==rs same instr: operands use old mapping.
//  - Operand resolve, priority order per operand:
//    index 0 -> V=0,Q=0,R=1; !rf_busy -> rf_val,Q=0,R=1; rob_rdy -> rob_val;
//    then ALU, LSB, commit broadcast with matching tag -> res (same-cycle bypass;
//    Rs misses broadcasts for entries written that edge); else V=0,Q=rf_tag,R=0.
//  - Broadcast valid but tag mismatch: ignored. Several matching: ALU > LSB > commit (equal values).
//  - clear: hold dropped at posedge, no strobe that cycle, no accept; clear beats fire.
//  - rdy=0: hold reg frozen, no accept, no strobes.
//  - Reset (rst=0, async): h_valid=0, hold fields 0; all strobes and buses 0 immediately.
//  - Stall on full holds the instruction unchanged; operands re-resolved every cycle.
// TESTING
//  - rst=0 mid-hold -> strobes and iq_ready drop same cycle; after rst=1 first instr issues normally.
//  - Add x3=x1+x2, x1/x2 not busy (vals 5,7) -> is_issue=1, Vi=5,Vj=7,Ri=Rj=1,Qi=Qj=0, rename x3->rob_tail.
//  - rs1 busy tag 4, rob_rdy1=0, is_alu_ok tag 4 res 0x2A same cycle -> issue_Vi=0x2A, Ri=1, Qi=0.
//  - rs2 busy tag 9, no broadcast -> Rj=0, Qj=9, Vj=0; rs1=x0 -> Vi=0, Ri=1.
//  - Load with lsb_full=1 for 3 cycles -> no strobes, iq_ready=0, issues cycle 4 via is_lsb_issue only.
//  - clear while HELD and rob_full=0 -> no strobe; next cycle h_valid=0, iq_ready=1; rd=0 -> rename_en=0.

Source files
------------

// File: rtl/dispatcher.sv
// Issue stage: holds one predecoded instruction, resolves its operands from regfile/ROB/broadcasts,
// allocates the ROB tail entry, renames rd and issues to the reservation station or the LSB.
module dispatcher #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             iq_valid,
    output logic             iq_ready,
    input  logic [OPC_W-1:0] iq_opcode,
    input  logic             iq_is_ls,
    input  logic [4:0]       iq_rd,
    input  logic [4:0]       iq_rs1,
    input  logic [4:0]       iq_rs2,
    input  logic [XLEN-1:0]  iq_imm,
    input  logic [XLEN-1:0]  iq_pc,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic             rf_busy1,
    input  logic             rf_busy2,
    input  logic [TAG_W-1:0] rf_tag1,
    input  logic [TAG_W-1:0] rf_tag2,
    input  logic [XLEN-1:0]  rf_val1,
    input  logic [XLEN-1:0]  rf_val2,
    input  logic             rob_rdy1,
    input  logic             rob_rdy2,
    input  logic [XLEN-1:0]  rob_val1,
    input  logic [XLEN-1:0]  rob_val2,
    input  logic             rob_full,
    input  logic [TAG_W-1:0] rob_tail,
    output logic             rob_issue,
    output logic [OPC_W-1:0] rob_opcode,
    output logic [4:0]       rob_rd,
    output logic [XLEN-1:0]  rob_pc,
    output logic             rename_en,
    output logic [4:0]       rename_rd,
    output logic [TAG_W-1:0] rename_tag,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             is_issue,
    output logic             is_lsb_issue,
    output logic [OPC_W-1:0] issue_opcode,
    output logic [TAG_W-1:0] issue_rob_id,
    output logic [XLEN-1:0]  issue_imm,
    output logic [XLEN-1:0]  issue_pc,
    output logic [XLEN-1:0]  issue_Vi,
    output logic [TAG_W-1:0] issue_Qi,
    output logic             issue_Ri,
    output logic [XLEN-1:0]  issue_Vj,
    output logic [TAG_W-1:0] issue_Qj,
    output logic             issue_Rj,
    input  logic             is_alu_ok,
    input  logic [TAG_W-1:0] rob_id_from_alu,
    input  logic [XLEN-1:0]  res_from_alu,
    input  logic             is_lsb_ok,
    input  logic [TAG_W-1:0] rob_id_from_lsb,
    input  logic [XLEN-1:0]  res_from_lsb,
    input  logic             is_rob_commit,
    input  logic [TAG_W-1:0] rob_id_from_rob,
    input  logic [XLEN-1:0]  res_from_rob
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    typedef struct packed {
        logic [0:0]       valid;
        logic [OPC_W-1:0] opcode;
        logic             is_ls;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } hold_t;

    hold_t                 hold_q;
    hold_t                 hold_d;
    logic                  fire_s;
    logic                  accept_s;
    logic [XLEN+TAG_W:0]   opnd1_s;
    logic [XLEN+TAG_W:0]   opnd2_s;

    // Returns {ready, tag, value}; a same-cycle broadcast counts as ready data.
    function automatic logic [XLEN+TAG_W:0] resolve(
        input logic [4:0]       idx,
        input logic             busy,
        input logic [TAG_W-1:0] tag,
        input logic [XLEN-1:0]  rf_val,
        input logic             rob_rdy,
        input logic [XLEN-1:0]  rob_val,
        input logic             alu_ok,
        input logic [TAG_W-1:0] alu_id,
        input logic [XLEN-1:0]  alu_res,
        input logic             lsb_ok,
        input logic [TAG_W-1:0] lsb_id,
        input logic [XLEN-1:0]  lsb_res,
        input logic             cm_ok,
        input logic [TAG_W-1:0] cm_id,
        input logic [XLEN-1:0]  cm_res
    );
        logic [XLEN+TAG_W:0] res;
        if (idx == 5'd0) begin
            res = {1'b1, {TAG_W{1'b0}}, {XLEN{1'b0}}};
        end else if (!busy) begin
            res = {1'b1, {TAG_W{1'b0}}, rf_val};
        end else if (rob_rdy) begin
            res = {1'b1, {TAG_W{1'b0}}, rob_val};
        end else if (alu_ok && (alu_id == tag)) begin
            res = {1'b1, {TAG_W{1'b0}}, alu_res};
        end else if (lsb_ok && (lsb_id == tag)) begin
            res = {1'b1, {TAG_W{1'b0}}, lsb_res};
        end else if (cm_ok && (cm_id == tag)) begin
            res = {1'b1, {TAG_W{1'b0}}, cm_res};
        end else begin
            res = {1'b0, tag, {XLEN{1'b0}}};
        end
        return res;
    endfunction

    // Issue condition and queue handshake; iq_ready also drops while reset is asserted.
    always_comb begin
        fire_s   = hold_q.valid[0] & rdy & ~clear & ~rob_full &
                   (hold_q.is_ls ? ~lsb_full : ~rs_full);
        iq_ready = rst & rdy & ~clear & (~hold_q.valid[0] | fire_s);
        accept_s = iq_valid & iq_ready;
    end

    // Hold register next state: clear beats both accept and fire.
    always_comb begin
        hold_d = hold_q;
        if (!rdy) begin
            hold_d = hold_q;
        end else if (clear) begin
            hold_d.valid = ST_EMPTY;
        end else if (accept_s) begin
            hold_d.valid  = ST_HELD;
            hold_d.opcode = iq_opcode;
            hold_d.is_ls  = iq_is_ls;
            hold_d.rd     = iq_rd;
            hold_d.rs1    = iq_rs1;
            hold_d.rs2    = iq_rs2;
            hold_d.imm    = iq_imm;
            hold_d.pc     = iq_pc;
        end else if (fire_s) begin
            hold_d.valid = ST_EMPTY;
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= {$bits(hold_t){1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end

    assign rf_rs1 = hold_q.rs1;
    assign rf_rs2 = hold_q.rs2;

    assign opnd1_s = resolve(hold_q.rs1, rf_busy1, rf_tag1, rf_val1, rob_rdy1, rob_val1,
                             is_alu_ok, rob_id_from_alu, res_from_alu,
                             is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                             is_rob_commit, rob_id_from_rob, res_from_rob);
    assign opnd2_s = resolve(hold_q.rs2, rf_busy2, rf_tag2, rf_val2, rob_rdy2, rob_val2,
                             is_alu_ok, rob_id_from_alu, res_from_alu,
                             is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                             is_rob_commit, rob_id_from_rob, res_from_rob);

    // Strobes and issue buses: driven only in a firing cycle, zero otherwise.
    always_comb begin
        rob_issue    = 1'b0;
        rob_opcode   = {OPC_W{1'b0}};
        rob_rd       = 5'd0;
        rob_pc       = {XLEN{1'b0}};
        rename_en    = 1'b0;
        rename_rd    = 5'd0;
        rename_tag   = {TAG_W{1'b0}};
        is_issue     = 1'b0;
        is_lsb_issue = 1'b0;
        issue_opcode = {OPC_W{1'b0}};
        issue_rob_id = {TAG_W{1'b0}};
        issue_imm    = {XLEN{1'b0}};
        issue_pc     = {XLEN{1'b0}};
        issue_Vi     = {XLEN{1'b0}};
        issue_Qi     = {TAG_W{1'b0}};
        issue_Ri     = 1'b0;
        issue_Vj     = {XLEN{1'b0}};
        issue_Qj     = {TAG_W{1'b0}};
        issue_Rj     = 1'b0;
        if (fire_s) begin
            rob_issue    = 1'b1;
            rob_opcode   = hold_q.opcode;
            rob_rd       = hold_q.rd;
            rob_pc       = hold_q.pc;
            rename_en    = (hold_q.rd != 5'd0);
            rename_rd    = hold_q.rd;
            rename_tag   = rob_tail;
            is_issue     = ~hold_q.is_ls;
            is_lsb_issue = hold_q.is_ls;
            issue_opcode = hold_q.opcode;
            issue_rob_id = rob_tail;
            issue_imm    = hold_q.imm;
            issue_pc     = hold_q.pc;
            {issue_Ri, issue_Qi, issue_Vi} = opnd1_s;
            {issue_Rj, issue_Qj, issue_Vj} = opnd2_s;
        end else begin
            rob_issue    = 1'b0;
            is_issue     = 1'b0;
            is_lsb_issue = 1'b0;
            rename_en    = 1'b0;
        end
    end

endmodule

// File: tb/tb_dispatcher.sv
// Bench for dispatcher: directed operand-resolution vectors, multi-cycle corner sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_dispatcher;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        iq_valid, iq_ready, iq_is_ls;
    logic [5:0]  iq_opcode;
    logic [4:0]  iq_rd, iq_rs1, iq_rs2;
    logic [31:0] iq_imm, iq_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        rf_busy1, rf_busy2, rob_rdy1, rob_rdy2, rob_full;
    logic [3:0]  rf_tag1, rf_tag2, rob_tail;
    logic [31:0] rf_val1, rf_val2, rob_val1, rob_val2;
    logic        rob_issue, rename_en, rs_full, lsb_full, is_issue, is_lsb_issue;
    logic [5:0]  rob_opcode, issue_opcode;
    logic [4:0]  rob_rd, rename_rd;
    logic [31:0] rob_pc, issue_imm, issue_pc, issue_Vi, issue_Vj;
    logic [3:0]  rename_tag, issue_rob_id, issue_Qi, issue_Qj;
    logic        issue_Ri, issue_Rj;
    logic        is_alu_ok, is_lsb_ok, is_rob_commit;
    logic [3:0]  rob_id_from_alu, rob_id_from_lsb, rob_id_from_rob;
    logic [31:0] res_from_alu, res_from_lsb, res_from_rob;

    int n_tests = 0;
    int n_fail  = 0;

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_opcode(iq_opcode), .iq_is_ls(iq_is_ls),
        .iq_rd(iq_rd), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_imm(iq_imm), .iq_pc(iq_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
        .rf_tag1(rf_tag1), .rf_tag2(rf_tag2), .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
        .rob_full(rob_full), .rob_tail(rob_tail), .rob_issue(rob_issue),
        .rob_opcode(rob_opcode), .rob_rd(rob_rd), .rob_pc(rob_pc),
        .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
        .rs_full(rs_full), .lsb_full(lsb_full), .is_issue(is_issue), .is_lsb_issue(is_lsb_issue),
        .issue_opcode(issue_opcode), .issue_rob_id(issue_rob_id), .issue_imm(issue_imm),
        .issue_pc(issue_pc), .issue_Vi(issue_Vi), .issue_Qi(issue_Qi), .issue_Ri(issue_Ri),
        .issue_Vj(issue_Vj), .issue_Qj(issue_Qj), .issue_Rj(issue_Rj),
        .is_alu_ok(is_alu_ok), .rob_id_from_alu(rob_id_from_alu), .res_from_alu(res_from_alu),
        .is_lsb_ok(is_lsb_ok), .rob_id_from_lsb(rob_id_from_lsb), .res_from_lsb(res_from_lsb),
        .is_rob_commit(is_rob_commit), .rob_id_from_rob(rob_id_from_rob), .res_from_rob(res_from_rob)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iq_ready;
        logic [4:0]  rf_rs1, rf_rs2;
        logic        rob_issue;
        logic [5:0]  rob_opcode;
        logic [4:0]  rob_rd;
        logic [31:0] rob_pc;
        logic        rename_en;
        logic [4:0]  rename_rd;
        logic [3:0]  rename_tag;
        logic        is_issue, is_lsb_issue;
        logic [5:0]  issue_opcode;
        logic [3:0]  issue_rob_id;
        logic [31:0] issue_imm, issue_pc, vi;
        logic [3:0]  qi;
        logic        ri;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic        rj;
    } out_t;

    typedef struct packed {
        logic [5:0]  opc;
        logic        is_ls;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
    } instr_t;

    typedef struct {
        logic is_ls; logic [4:0] rd, rs1, rs2;
        logic b1; logic [3:0] t1; logic [31:0] v1; logic rr1; logic [31:0] rv1;
        logic b2; logic [3:0] t2; logic [31:0] v2; logic rr2; logic [31:0] rv2;
        logic a_ok; logic [3:0] a_id; logic [31:0] a_res;
        logic l_ok; logic [3:0] l_id; logic [31:0] l_res;
        logic c_ok; logic [3:0] c_id; logic [31:0] c_res;
        logic [31:0] e_vi; logic [3:0] e_qi; logic e_ri;
        logic [31:0] e_vj; logic [3:0] e_qj; logic e_rj;
        logic e_ren;
    } vec_t;

    vec_t   vecs[7];
    logic   m_valid;
    instr_t m_ins;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic neutral();
        rdy = 1'b1; clear = 1'b0; iq_valid = 1'b0;
        rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = 4'd0; rf_tag2 = 4'd0;
        rf_val1 = 32'd0; rf_val2 = 32'd0; rob_rdy1 = 1'b0; rob_rdy2 = 1'b0;
        rob_val1 = 32'd0; rob_val2 = 32'd0; rob_full = 1'b0; rob_tail = 4'd0;
        rs_full = 1'b0; lsb_full = 1'b0;
        is_alu_ok = 1'b0; rob_id_from_alu = 4'd0; res_from_alu = 32'd0;
        is_lsb_ok = 1'b0; rob_id_from_lsb = 4'd0; res_from_lsb = 32'd0;
        is_rob_commit = 1'b0; rob_id_from_rob = 4'd0; res_from_rob = 32'd0;
    endtask

    // One-cycle accept of an instruction into an empty (or firing) hold register.
    task automatic present(input logic [5:0] opc, input logic ls, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc);
        iq_valid = 1'b1; iq_opcode = opc; iq_is_ls = ls; iq_rd = rd;
        iq_rs1 = rs1; iq_rs2 = rs2; iq_imm = imm; iq_pc = pc;
        tick();
        iq_valid = 1'b0;
    endtask

    function automatic out_t dut_out();
        return out_t'({iq_ready, rf_rs1, rf_rs2, rob_issue, rob_opcode, rob_rd, rob_pc,
                       rename_en, rename_rd, rename_tag, is_issue, is_lsb_issue,
                       issue_opcode, issue_rob_id, issue_imm, issue_pc,
                       issue_Vi, issue_Qi, issue_Ri, issue_Vj, issue_Qj, issue_Rj});
    endfunction

    // First source in priority order that has data wins; otherwise wait on the tag.
    function automatic void ref_opnd(input logic [4:0] idx, input logic busy, input logic [3:0] tag,
                                     input logic [31:0] rfv, input logic rr, input logic [31:0] rv,
                                     output logic [31:0] v, output logic [3:0] q, output logic r);
        logic        hit[5];
        logic [31:0] src[5];
        hit = '{!busy, rr, is_alu_ok && rob_id_from_alu == tag,
                is_lsb_ok && rob_id_from_lsb == tag, is_rob_commit && rob_id_from_rob == tag};
        src = '{rfv, rv, res_from_alu, res_from_lsb, res_from_rob};
        v = 32'd0; q = tag; r = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (hit[i]) begin
                v = src[i]; q = 4'd0; r = 1'b1;
            end
        end
        if (idx == 5'd0) begin
            v = 32'd0; q = 4'd0; r = 1'b1;
        end
    endfunction

    function automatic logic model_fire();
        return m_valid && rdy && !clear && !rob_full && (m_ins.is_ls ? !lsb_full : !rs_full);
    endfunction

    function automatic out_t model_out();
        out_t e;
        logic f;
        e = '0;
        f = model_fire();
        e.iq_ready = rdy && !clear && (!m_valid || f);
        e.rf_rs1 = m_ins.rs1;
        e.rf_rs2 = m_ins.rs2;
        if (f) begin
            e.rob_issue = 1'b1; e.rob_opcode = m_ins.opc; e.rob_rd = m_ins.rd; e.rob_pc = m_ins.pc;
            e.rename_en = (m_ins.rd != 5'd0); e.rename_rd = m_ins.rd; e.rename_tag = rob_tail;
            e.is_issue = !m_ins.is_ls; e.is_lsb_issue = m_ins.is_ls;
            e.issue_opcode = m_ins.opc; e.issue_rob_id = rob_tail;
            e.issue_imm = m_ins.imm; e.issue_pc = m_ins.pc;
            ref_opnd(m_ins.rs1, rf_busy1, rf_tag1, rf_val1, rob_rdy1, rob_val1, e.vi, e.qi, e.ri);
            ref_opnd(m_ins.rs2, rf_busy2, rf_tag2, rf_val2, rob_rdy2, rob_val2, e.vj, e.qj, e.rj);
        end
        return e;
    endfunction

    function automatic logic [3:0] pick_tag();
        case ($urandom_range(2))
            0: return rf_tag1;
            1: return rf_tag2;
            default: return 4'($urandom_range(15));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        out_t   got, exp;
        logic   f, acc;
        vecs[0] = '{1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 4'd0, 32'd5, 1'b0, 32'd0, 1'b0, 4'd0, 32'd7, 1'b0, 32'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 4'd4, 32'hDEAD, 1'b0, 32'd0, 1'b0, 4'd0, 32'd7, 1'b0, 32'd0,
                    1'b1, 4'd4, 32'h2A, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'h2A, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 5'd6, 5'd0, 5'd2, 1'b1, 4'd3, 32'h55, 1'b0, 32'd0, 1'b1, 4'd9, 32'h1234, 1'b0, 32'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'd0, 4'd0, 1'b1, 32'd0, 4'd9, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 5'd7, 5'd1, 5'd2, 1'b1, 4'd2, 32'd0, 1'b1, 32'h100, 1'b1, 4'd5, 32'd0, 1'b0, 32'd0,
                    1'b1, 4'd2, 32'h999, 1'b1, 4'd5, 32'h77, 1'b1, 4'd5, 32'h88,
                    32'h100, 4'd0, 1'b1, 32'h77, 4'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 5'd8, 5'd1, 5'd2, 1'b1, 4'd6, 32'd0, 1'b0, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0, 32'd0,
                    1'b1, 4'd7, 32'h11, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'hC0,
                    32'd0, 4'd6, 1'b0, 32'hC0, 4'd0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 4'd0, 32'h1000, 1'b0, 32'd0, 1'b1, 4'd2, 32'h9, 1'b0, 32'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0,
                    32'h1000, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 5'd9, 5'd1, 5'd2, 1'b1, 4'd3, 32'd0, 1'b0, 32'd0, 1'b1, 4'd3, 32'd0, 1'b0, 32'd0,
                    1'b1, 4'd3, 32'hA, 1'b1, 4'd3, 32'hB, 1'b0, 4'd0, 32'd0,
                    32'hA, 4'd0, 1'b1, 32'hA, 4'd0, 1'b1, 1'b1};

        neutral();
        rst = 1'b0;
        iq_opcode = 6'd0; iq_is_ls = 1'b0; iq_rd = 5'd0; iq_rs1 = 5'd0; iq_rs2 = 5'd0;
        iq_imm = 32'd0; iq_pc = 32'd0;
        tick(); tick();
        check("reset_strobes", {rob_issue, is_issue, is_lsb_issue, rename_en}, 4'b0000);
        check("reset_iq_ready", iq_ready, 1'b0);
        check("reset_rf_idx", {rf_rs1, rf_rs2}, 10'd0);
        rst = 1'b1;
        #2;
        check("empty_iq_ready", iq_ready, 1'b1);

        // Directed operand-resolution vectors.
        for (int i = 0; i < 7; i++) begin
            neutral();
            present(6'(i + 1), vecs[i].is_ls, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
            rob_tail = 4'(i + 3);
            rf_busy1 = vecs[i].b1; rf_tag1 = vecs[i].t1; rf_val1 = vecs[i].v1;
            rob_rdy1 = vecs[i].rr1; rob_val1 = vecs[i].rv1;
            rf_busy2 = vecs[i].b2; rf_tag2 = vecs[i].t2; rf_val2 = vecs[i].v2;
            rob_rdy2 = vecs[i].rr2; rob_val2 = vecs[i].rv2;
            is_alu_ok = vecs[i].a_ok; rob_id_from_alu = vecs[i].a_id; res_from_alu = vecs[i].a_res;
            is_lsb_ok = vecs[i].l_ok; rob_id_from_lsb = vecs[i].l_id; res_from_lsb = vecs[i].l_res;
            is_rob_commit = vecs[i].c_ok; rob_id_from_rob = vecs[i].c_id; res_from_rob = vecs[i].c_res;
            #2;
            check($sformatf("vec%0d_op1", i), {issue_Vi, issue_Qi, issue_Ri},
                  {vecs[i].e_vi, vecs[i].e_qi, vecs[i].e_ri});
            check($sformatf("vec%0d_op2", i), {issue_Vj, issue_Qj, issue_Rj},
                  {vecs[i].e_vj, vecs[i].e_qj, vecs[i].e_rj});
            check($sformatf("vec%0d_strobes", i), {is_issue, is_lsb_issue, rob_issue, rename_en},
                  {!vecs[i].is_ls, vecs[i].is_ls, 1'b1, vecs[i].e_ren});
            check($sformatf("vec%0d_ids", i), {issue_rob_id, rename_tag, rename_rd, issue_opcode, issue_pc},
                  {4'(i + 3), 4'(i + 3), vecs[i].rd, 6'(i + 1), 32'h4000 + 32'(4 * i)});
            tick();
        end

        // Async reset while an instruction is firing.
        neutral();
        present(6'd1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h10);
        #2;
        check("pre_rst_fire", {is_issue, iq_ready}, 2'b11);
        rst = 1'b0;
        #1;
        check("rst_mid_hold", {is_issue, rob_issue, iq_ready}, 3'b000);
        tick();
        rst = 1'b1;
        present(6'd2, 1'b0, 5'd4, 5'd1, 5'd0, 32'd0, 32'h20);
        rob_tail = 4'd6; rf_val1 = 32'd9;
        #2;
        check("post_rst_issue", {is_issue, rob_issue, rename_tag, issue_Vi, issue_pc},
              {1'b1, 1'b1, 4'd6, 32'd9, 32'h20});
        tick();

        // Load stalled by lsb_full for three cycles.
        neutral();
        present(6'd3, 1'b1, 5'd5, 5'd1, 5'd2, 32'd0, 32'h30);
        lsb_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("lsb_stall%0d", c), {is_issue, is_lsb_issue, rob_issue, iq_ready}, 4'b0000);
            tick();
        end
        lsb_full = 1'b0;
        #2;
        check("lsb_release", {is_issue, is_lsb_issue, rob_issue, issue_pc}, {3'b011, 32'h30});
        tick();

        // Clear while held, then an rd=0 instruction issues without rename.
        neutral();
        present(6'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'h40);
        clear = 1'b1;
        #2;
        check("clear_no_strobe", {is_issue, rob_issue, iq_ready}, 3'b000);
        tick();
        clear = 1'b0;
        #2;
        check("after_clear", {is_issue, rob_issue, iq_ready}, 3'b001);
        present(6'd5, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'h44);
        #2;
        check("rd0_no_rename", {rob_issue, rename_en}, 2'b10);
        tick();

        // rdy=0 freezes a held instruction.
        neutral();
        present(6'd6, 1'b0, 5'd7, 5'd1, 5'd2, 32'd0, 32'h50);
        rdy = 1'b0;
        #2;
        check("rdy0_frozen", {is_issue, rob_issue, iq_ready}, 3'b000);
        tick();
        rdy = 1'b1;
        #2;
        check("rdy1_issue", {is_issue, rob_pc}, {1'b1, 32'h50});
        tick();

        // Randomized traffic against the reference model.
        neutral();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        m_valid = 1'b0;
        m_ins = '0;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy = ($urandom_range(7) != 0);
            clear = ($urandom_range(15) == 0);
            rob_full = ($urandom_range(5) == 0);
            rs_full = ($urandom_range(3) == 0);
            lsb_full = ($urandom_range(3) == 0);
            iq_valid = ($urandom_range(3) != 0);
            iq_opcode = 6'($urandom); iq_is_ls = 1'($urandom);
            iq_rd = 5'($urandom_range(7)); iq_rs1 = 5'($urandom_range(7)); iq_rs2 = 5'($urandom_range(7));
            iq_imm = $urandom; iq_pc = $urandom;
            rf_busy1 = 1'($urandom); rf_busy2 = 1'($urandom);
            rf_tag1 = 4'($urandom); rf_tag2 = 4'($urandom);
            rf_val1 = $urandom; rf_val2 = $urandom;
            rob_rdy1 = ($urandom_range(3) == 0); rob_rdy2 = ($urandom_range(3) == 0);
            rob_val1 = $urandom; rob_val2 = $urandom; rob_tail = 4'($urandom);
            is_alu_ok = 1'($urandom); rob_id_from_alu = pick_tag(); res_from_alu = $urandom;
            is_lsb_ok = 1'($urandom); rob_id_from_lsb = pick_tag(); res_from_lsb = $urandom;
            is_rob_commit = 1'($urandom); rob_id_from_rob = pick_tag(); res_from_rob = $urandom;
            #2;
            got = dut_out();
            exp = model_out();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: got %h expected %h", cyc, got, exp);
            end
            f = model_fire();
            acc = iq_valid && exp.iq_ready;
            tick();
            if (rdy) begin
                if (clear) begin
                    m_valid = 1'b0;
                end else if (acc) begin
                    m_valid = 1'b1;
                    m_ins = '{iq_opcode, iq_is_ls, iq_rd, iq_rs1, iq_rs2, iq_imm, iq_pc};
                end else if (f) begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
